// File: rtl/mouse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mouse_pkg
// Description : Shared constants and types for the mouse cursor tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package mouse_pkg;

    localparam int BTN_L  = 0;
    localparam int BTN_R  = 1;
    localparam int BTN_M  = 2;
    localparam int PS2_DW = 9;

    typedef enum logic [1:0] {
        DC_IDLE  = 2'd0,
        DC_DOWN1 = 2'd1,
        DC_UP1   = 2'd2,
        DC_DOWN2 = 2'd3
    } dclk_state_t;

endpackage
`default_nettype wire

// File: rtl/axis_accum.sv
`default_nettype none
// ============================================================================
// Module      : axis_accum
// Description : One cursor axis: scaled signed delta accumulated into a
//               position register that either saturates or wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_accum
    import mouse_pkg::*;
#(
    parameter int W     = 10,
    parameter int SHIFT = 0,
    parameter int WRAP  = 0,
    parameter int NEG   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_en,
    input  logic              load_centre,
    input  logic [PS2_DW-1:0] delta,
    output logic [W-1:0]      pos
);

    localparam int                     SW      = W + 2;
    localparam logic [W-1:0]           CENTRE  = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [SW-1:0]   POS_MAX = $signed({2'b00, {W{1'b1}}});

    logic signed [SW-1:0] delta_ext;
    logic signed [SW-1:0] delta_shr;
    logic signed [SW-1:0] step;
    logic signed [SW-1:0] sum;
    logic [W-1:0]         pos_q, pos_d;

    // W+2 bits holds pos + |delta| <= 2^W-1 + 256 without overflow for W >= 9
    always_comb begin
        delta_ext = $signed({{(SW-PS2_DW){delta[PS2_DW-1]}}, delta});
        delta_shr = delta_ext >>> SHIFT;
        step      = (NEG != 0) ? -delta_shr : delta_shr;
        sum       = $signed({2'b00, pos_q}) + step;
        pos_d     = pos_q;
        if (upd_en) begin
            if (load_centre)
                pos_d = CENTRE;
            else if (WRAP != 0)
                pos_d = sum[W-1:0];
            else if (sum < 0)
                pos_d = '0;
            else if (sum > POS_MAX)
                pos_d = '1;
            else
                pos_d = sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            pos_q <= CENTRE;
        else
            pos_q <= pos_d;
    end

    assign pos = pos_q;

endmodule
`default_nettype wire

// File: rtl/mouse_pos_tracker.sv
`default_nettype none
// ============================================================================
// Module      : mouse_pos_tracker
// Description : 2-D cursor tracker fed by decoded PS/2 packets, with LED bar
//               and left-button double-click detection.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_pos_tracker
    import mouse_pkg::*;
#(
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int N_LED    = 8,
    parameter int SHIFT    = 0,
    parameter int WRAP     = 0,
    parameter int INVERT_Y = 1,
    parameter int DCLK_CYC = 12_500_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PS2_DW-1:0] xm,
    input  logic [PS2_DW-1:0] ym,
    input  logic [2:0]        btnm,
    input  logic              m_done_tick,
    output logic [X_W-1:0]    x_pos,
    output logic [Y_W-1:0]    y_pos,
    output logic [2:0]        btn,
    output logic [N_LED-1:0]  led,
    output logic              upd_tick,
    output logic              dclick_tick
);

    localparam int               LOG2N    = $clog2(N_LED);
    localparam int               TW       = $clog2(DCLK_CYC + 1);
    localparam logic [TW-1:0]    DCLK_MAX = TW'(DCLK_CYC);
    localparam logic [N_LED-1:0] LED_RST  = N_LED'(1) << (N_LED/2 - 1);

    logic              pkt_v_q, pkt_v_d;
    logic [PS2_DW-1:0] pkt_x_q, pkt_x_d;
    logic [PS2_DW-1:0] pkt_y_q, pkt_y_d;
    logic [2:0]        pkt_btn_q, pkt_btn_d;
    logic [2:0]        btn_q, btn_d;
    logic              upd_tick_q, upd_tick_d;
    logic              dclick_q, dclick_d;
    logic [N_LED-1:0]  led_q, led_d;
    logic [LOG2N-1:0]  led_k;
    logic [TW-1:0]     timer_q, timer_d;
    dclk_state_t       state_q, state_d;
    logic              left;

    always_comb begin
        pkt_v_d    = m_done_tick;
        pkt_x_d    = m_done_tick ? xm   : pkt_x_q;
        pkt_y_d    = m_done_tick ? ym   : pkt_y_q;
        pkt_btn_d  = m_done_tick ? btnm : pkt_btn_q;
        btn_d      = pkt_v_q ? pkt_btn_q : btn_q;
        upd_tick_d = pkt_v_q;
    end

    axis_accum #(.W(X_W), .SHIFT(SHIFT), .WRAP(WRAP), .NEG(0)) u_axis_x (
        .clk         (clk),
        .reset       (reset),
        .upd_en      (pkt_v_q),
        .load_centre (pkt_btn_q[BTN_M]),
        .delta       (pkt_x_q),
        .pos         (x_pos)
    );

    axis_accum #(.W(Y_W), .SHIFT(SHIFT), .WRAP(WRAP), .NEG(INVERT_Y)) u_axis_y (
        .clk         (clk),
        .reset       (reset),
        .upd_en      (pkt_v_q),
        .load_centre (pkt_btn_q[BTN_M]),
        .delta       (pkt_y_q),
        .pos         (y_pos)
    );

    // x = 0 lights the MSB LED
    always_comb begin
        led_k = x_pos[X_W-1 -: LOG2N];
        led_d = '0;
        for (int i = 0; i < N_LED; i++)
            led_d[i] = (led_k == LOG2N'(N_LED - 1 - i));
    end

    // Decisions use the packet that becomes btn at the next edge, so the
    // dclick pulse lines up with upd_tick.
    always_comb begin
        left     = pkt_btn_q[BTN_L];
        state_d  = state_q;
        timer_d  = timer_q;
        dclick_d = 1'b0;
        case (state_q)
            DC_IDLE:  if (pkt_v_q && left) state_d = DC_DOWN1;
            DC_DOWN1: if (pkt_v_q && !left) begin
                state_d = DC_UP1;
                timer_d = '0;
            end
            DC_UP1: begin
                if (timer_q < DCLK_MAX)
                    timer_d = timer_q + 1'b1;
                if (pkt_v_q && left) begin
                    if (timer_q < DCLK_MAX) begin
                        state_d  = DC_DOWN2;
                        dclick_d = 1'b1;
                    end else begin
                        state_d = DC_DOWN1;
                    end
                end else if (timer_q >= DCLK_MAX) begin
                    state_d = DC_IDLE;
                end
            end
            DC_DOWN2: if (pkt_v_q && !left) state_d = DC_IDLE;
            default:  state_d = DC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_v_q    <= 1'b0;
            pkt_x_q    <= '0;
            pkt_y_q    <= '0;
            pkt_btn_q  <= '0;
            btn_q      <= '0;
            upd_tick_q <= 1'b0;
            dclick_q   <= 1'b0;
            led_q      <= LED_RST;
            timer_q    <= '0;
            state_q    <= DC_IDLE;
        end else begin
            pkt_v_q    <= pkt_v_d;
            pkt_x_q    <= pkt_x_d;
            pkt_y_q    <= pkt_y_d;
            pkt_btn_q  <= pkt_btn_d;
            btn_q      <= btn_d;
            upd_tick_q <= upd_tick_d;
            dclick_q   <= dclick_d;
            led_q      <= led_d;
            timer_q    <= timer_d;
            state_q    <= state_d;
        end
    end

    assign btn         = btn_q;
    assign led         = led_q;
    assign upd_tick    = upd_tick_q;
    assign dclick_tick = dclick_q;

endmodule
`default_nettype wire

// File: tb/tb_mouse_pos_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mouse_pos_tracker
// Description : Directed self-checking bench for mouse_pos_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mouse_pos_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] xm = '0;
    logic [8:0] ym = '0;
    logic [2:0] btnm = '0;
    logic       m_done_tick = 1'b0;

    logic [9:0] x_a, y_a, x_w, y_w, x_s, y_s;
    logic [2:0] btn_a, btn_w, btn_s;
    logic [7:0] led_a, led_w, led_s;
    logic       upd_a, upd_w, upd_s, dc_a, dc_w, dc_s;

    int n_checks = 0;
    int n_pass   = 0;
    int n_dclk   = 0;

    always #5 clk = ~clk;

    mouse_pos_tracker #(.DCLK_CYC(100)) u_dut (
        .clk(clk), .reset(reset), .xm(xm), .ym(ym), .btnm(btnm),
        .m_done_tick(m_done_tick), .x_pos(x_a), .y_pos(y_a), .btn(btn_a),
        .led(led_a), .upd_tick(upd_a), .dclick_tick(dc_a));

    mouse_pos_tracker #(.WRAP(1), .DCLK_CYC(100)) u_wrap (
        .clk(clk), .reset(reset), .xm(xm), .ym(ym), .btnm(btnm),
        .m_done_tick(m_done_tick), .x_pos(x_w), .y_pos(y_w), .btn(btn_w),
        .led(led_w), .upd_tick(upd_w), .dclick_tick(dc_w));

    mouse_pos_tracker #(.SHIFT(2), .DCLK_CYC(100)) u_shift (
        .clk(clk), .reset(reset), .xm(xm), .ym(ym), .btnm(btnm),
        .m_done_tick(m_done_tick), .x_pos(x_s), .y_pos(y_s), .btn(btn_s),
        .led(led_s), .upd_tick(upd_s), .dclick_tick(dc_s));

    always @(negedge clk)
        if (dc_a) n_dclk++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Tick is high for one full cycle and sampled by exactly one posedge;
    // returns on the negedge right after that edge.
    task automatic send(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
        @(negedge clk);
        xm = x; ym = y; btnm = b; m_done_tick = 1'b1;
        @(negedge clk);
        m_done_tick = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_x",   x_a,   512);
        check("rst_y",   y_a,   512);
        check("rst_led", led_a, 8'b0000_1000);
        check("rst_btn", btn_a, 0);
        check("rst_upd", upd_a, 0);
        check("rst_dc",  dc_a,  0);

        // first packet latency and upd_tick width
        send(9'd5, 9'd3, 3'b000);
        check("lat_upd_n1", upd_a, 0);
        check("lat_x_n1",   x_a,   512);
        @(negedge clk);
        check("lat_upd_n2", upd_a, 1);
        check("lat_x_n2",   x_a,   517);
        check("lat_y_n2",   y_a,   509);
        check("lat_led_n2", led_a, 8'b0000_1000);
        @(negedge clk);
        check("lat_upd_n3", upd_a, 0);
        check("lat_led_n3", led_a, 8'b0000_1000);

        // saturation at both edges
        for (int i = 0; i < 10; i++) send(-9'sd128, 9'd0, 3'b000);
        settle();
        check("sat_lo_x",   x_a,   0);
        check("sat_lo_led", led_a, 8'b1000_0000);
        check("sat_lo_y",   y_a,   509);
        for (int i = 0; i < 10; i++) send(9'd127, 9'd0, 3'b000);
        settle();
        check("sat_hi_x",   x_a,   1023);
        check("sat_hi_led", led_a, 8'b0000_0001);

        // wrap vs saturate from x = 1020
        do_reset();
        for (int i = 0; i < 4; i++) send(9'd127, 9'd0, 3'b000);
        settle();
        check("wrap_pre_x", x_w, 1020);
        send(9'd10, 9'd0, 3'b000);
        settle();
        check("wrap_up_x",   x_w,   6);
        check("wrap_up_led", led_w, 8'b1000_0000);
        check("sat_up_x",    x_a,   1023);
        send(-9'sd10, 9'd0, 3'b000);
        settle();
        check("wrap_dn_x", x_w, 1020);
        check("sat_dn_x",  x_a, 1013);
        check("wrap_y",    y_w, 512);

        // sensitivity shift of 2 with floor rounding
        do_reset();
        send(-9'sd1, 9'd0, 3'b000);
        settle();
        check("shf_m1_x", x_s, 511);
        send(9'd3, 9'd0, 3'b000);
        settle();
        check("shf_p3_x", x_s, 511);
        send(9'd8, 9'd0, 3'b000);
        settle();
        check("shf_p8_x", x_s, 513);
        check("shf_y",    y_s, 512);

        // middle button recentres, overriding movement
        do_reset();
        for (int i = 0; i < 3; i++) send(-9'sd128, -9'sd128, 3'b000);
        send(-9'sd28, -9'sd4, 3'b000);
        settle();
        check("mid_pre_x", x_a, 100);
        check("mid_pre_y", y_a, 900);
        send(9'd50, 9'd0, 3'b100);
        settle();
        check("mid_x",   x_a,   512);
        check("mid_y",   y_a,   512);
        check("mid_btn", btn_a, 3'b100);

        // back-to-back ticks; right button has no position effect
        @(negedge clk);
        xm = 9'd10; ym = 9'd0; btnm = 3'b000; m_done_tick = 1'b1;
        @(negedge clk);
        xm = 9'd20; btnm = 3'b010;
        @(negedge clk);
        m_done_tick = 1'b0;
        check("b2b_first_x", x_a, 522);
        @(negedge clk);
        check("b2b_x",   x_a,   542);
        check("b2b_btn", btn_a, 3'b010);
        check("b2b_upd", upd_a, 1);

        // double-click inside the window
        do_reset();
        send(9'd0, 9'd0, 3'b001);
        send(9'd0, 9'd0, 3'b000);
        repeat (50) @(negedge clk);
        send(9'd0, 9'd0, 3'b001);
        @(negedge clk);
        check("dc_in_upd", upd_a, 1);
        check("dc_in_dc",  dc_a,  1);
        @(negedge clk);
        check("dc_in_end", dc_a, 0);
        send(9'd0, 9'd0, 3'b000);
        settle();
        check("dc_in_cnt", n_dclk, 1);

        // second press after the window expires
        send(9'd0, 9'd0, 3'b001);
        send(9'd0, 9'd0, 3'b000);
        repeat (150) @(negedge clk);
        send(9'd0, 9'd0, 3'b001);
        @(negedge clk);
        check("dc_late_upd", upd_a, 1);
        check("dc_late_dc",  dc_a,  0);
        settle();
        check("dc_late_cnt", n_dclk, 1);

        // reset while waiting for the second press
        send(9'd0, 9'd0, 3'b000);
        repeat (5) @(negedge clk);
        do_reset();
        send(9'd0, 9'd0, 3'b001);
        @(negedge clk);
        check("dc_rst_upd", upd_a, 1);
        check("dc_rst_dc",  dc_a,  0);
        settle();
        check("dc_rst_cnt", n_dclk, 1);
        check("dc_rst_btn", btn_a, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
